// File: rtl/serial_tx_arbiter.sv
// ============================================================================
// serial_tx_arbiter
// ----------------------------------------------------------------------------
// Shares one external serializer among NUM_REQ parallel-word requesters.
// Requesters are served round-robin, one word at a time. The arbiter launches
// the serializer with a one-cycle start and follows its busy flag to find the
// end of the frame. After each frame it holds off for GAP_CYCLES idle cycles
// before it grants the next requester.
//
// Ports
//   clock        rising-edge clock (shared with the serializer)
//   reset        synchronous, active-high (shared with the serializer)
//   i_req        per-requester level request, held until its grant bit
//   i_req_data   requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_grant      one-hot, one-cycle pulse: the winner's word was captured
//   o_done       one-hot, one-cycle pulse: that requester's frame is out
//   o_active_id  index of the requester that currently owns the serializer
//   o_error      sticky: serializer never went busy after a start
//   o_ser_start  serializer start (high only while in LOAD)
//   o_ser_data   serializer data_in (the captured word)
//   i_ser_busy   serializer busy
// ============================================================================
module serial_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic [$clog2(NUM_REQ)-1:0]    o_active_id,
    output logic                          o_error,
    output logic                          o_ser_start,
    output logic [DATA_WIDTH-1:0]         o_ser_data,
    input  logic                          i_ser_busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t                  r_state;
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      r_done;
    logic [DATA_WIDTH-1:0]   r_dataQ;
    logic [ID_W-1:0]         r_activeId;
    logic [ID_W-1:0]         r_lastId;
    logic                    r_error;
    logic                    r_waitMiss;
    logic [GAP_W-1:0]        r_gapCount;

    logic                    w_found;
    logic [ID_W-1:0]         w_cand;
    logic [ID_W-1:0]         w_winnerId;
    logic [NUM_REQ-1:0]      w_winnerOneHot;
    logic [DATA_WIDTH-1:0]   w_winnerData;
    logic [NUM_REQ-1:0]      w_activeOneHot;

    // Round-robin search: walk the requesters starting just after the last
    // winner and wrapping around. The last winner is checked at the very end,
    // so it only wins again when nobody else is asking.
    always_comb begin
        w_found    = 1'b0;
        w_cand     = '0;
        w_winnerId = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_cand = ID_W'((int'(r_lastId) + off) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found    = 1'b1;
                w_winnerId = w_cand;
            end
        end
    end

    // Pick the winner's word with a constant-offset mux. This avoids a
    // variable part-select.
    always_comb begin
        w_winnerData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winnerId == ID_W'(i)) begin
                w_winnerData = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_winnerOneHot = NUM_REQ'(1) << w_winnerId;
    assign w_activeOneHot = NUM_REQ'(1) << r_activeId;

    // Frame sequencer. The word and the owner id are captured only in IDLE,
    // so the serializer data stays stable from LOAD through SHIFT.
    // WAIT allows one edge of slack before busy must appear. If busy is still
    // low on the second edge, the serializer is declared faulty: no done is
    // sent and the gap is still enforced.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_done     <= '0;
            r_dataQ    <= '0;
            r_activeId <= '0;
            r_lastId   <= ID_W'(NUM_REQ - 1);
            r_error    <= 1'b0;
            r_waitMiss <= 1'b0;
            r_gapCount <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_winnerOneHot;
                        r_dataQ    <= w_winnerData;
                        r_activeId <= w_winnerId;
                        r_lastId   <= w_winnerId;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_waitMiss <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_ser_busy) begin
                        r_state <= S_SHIFT;
                    end else if (r_waitMiss) begin
                        r_error    <= 1'b1;
                        r_gapCount <= GAP_W'(GAP_CYCLES - 1);
                        r_state    <= S_GAP;
                    end else begin
                        r_waitMiss <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!i_ser_busy) begin
                        r_done     <= w_activeOneHot;
                        r_gapCount <= GAP_W'(GAP_CYCLES - 1);
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gapCount == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gapCount <= r_gapCount - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_done      = r_done;
    assign o_active_id = r_activeId;
    assign o_error     = r_error;
    assign o_ser_start = (r_state == S_LOAD);
    assign o_ser_data  = r_dataQ;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// ============================================================================
// tb_serial_tx_arbiter
// ----------------------------------------------------------------------------
// Drives serial_tx_arbiter together with a behavioural serializer. Expected
// grant/done events are queued by the stimulus. A negedge monitor pops the
// queue and compares the event every time the DUT pulses grant or done.
// ============================================================================
module tb_serial_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int GAP     = 2;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [NUM_REQ-1:0]      req = '0;
    logic [NUM_REQ*DW-1:0]   reqData = '0;
    logic [NUM_REQ-1:0]      o_grant;
    logic [NUM_REQ-1:0]      o_done;
    logic [1:0]              o_active_id;
    logic                    o_error;
    logic                    o_ser_start;
    logic [DW-1:0]           o_ser_data;
    logic                    serBusy;
    logic                    serLine;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int grantsSeen = 0;
    int donesSeen = 0;
    int lastGrantCycle = 0;
    bit faultMode = 1'b0;

    typedef struct {
        bit            isDone;
        int            id;
        logic [DW-1:0] data;
        int            period;
    } expT;

    expT expQ[$];
    expT monItem;

    serial_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_WIDTH(DW),
        .GAP_CYCLES(GAP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .i_req(req),
        .i_req_data(reqData),
        .o_grant(o_grant),
        .o_done(o_done),
        .o_active_id(o_active_id),
        .o_error(o_error),
        .o_ser_start(o_ser_start),
        .o_ser_data(o_ser_data),
        .i_ser_busy(serBusy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    // Behavioural serializer: it samples start while idle and then stays busy
    // for DW cycles, sending the word LSB first. The line idles high. In
    // fault mode it ignores start, so busy never rises.
    logic [DW-1:0] modelSh;
    int            modelCnt;
    always @(posedge clock) begin
        if (reset) begin
            serBusy  <= 1'b0;
            modelSh  <= '0;
            modelCnt <= 0;
        end else if (!serBusy) begin
            if (o_ser_start && !faultMode) begin
                modelSh  <= o_ser_data;
                serBusy  <= 1'b1;
                modelCnt <= DW;
            end
        end else begin
            modelSh  <= modelSh >> 1;
            modelCnt <= modelCnt - 1;
            if (modelCnt == 1) serBusy <= 1'b0;
        end
    end
    assign serLine = serBusy ? modelSh[0] : 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // The monitor rebuilds each serialized word from the line. It compares
    // every grant or done pulse against the next queued expectation.
    logic [DW-1:0] serWord = '0;
    always @(negedge clock) begin
        if (o_grant != '0) begin
            grantsSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_grant", 32'(o_grant), 32'd0);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("grant_onehot", 32'(o_grant), monItem.isDone ? 32'd0 : (32'd1 << monItem.id));
                checkOutput("grant_active_id", 32'(o_active_id), monItem.id);
                checkOutput("grant_ser_start", 32'(o_ser_start), 32'd1);
                checkOutput("grant_ser_data", 32'(o_ser_data), 32'(monItem.data));
                if (monItem.period != 0)
                    checkOutput("grant_period", cycle - lastGrantCycle, monItem.period);
            end
            lastGrantCycle = cycle;
        end
        if (o_done != '0) begin
            donesSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'(o_done), 32'd0);
            end else begin
                monItem = expQ.pop_front();
                checkOutput("done_onehot", 32'(o_done), monItem.isDone ? (32'd1 << monItem.id) : 32'd0);
                checkOutput("done_active_id", 32'(o_active_id), monItem.id);
                checkOutput("serial_word", 32'(serWord), 32'(monItem.data));
            end
        end
        if (o_ser_start && o_grant == '0)
            checkOutput("start_without_grant", 32'(o_ser_start), 32'd0);
        if (serBusy) serWord = {serLine, serWord[DW-1:1]};
    end

    task automatic stepCycle();
        @(negedge clock);
        #1;
    endtask

    task automatic applyStimulus(input int id, input logic [DW-1:0] data, input bit on);
        reqData[id*DW +: DW] = data;
        req[id] = on;
    endtask

    task automatic pushFrame(input int id, input logic [DW-1:0] data, input int period, input bit withDone);
        expT g;
        expT d;
        g.isDone = 1'b0; g.id = id; g.data = data; g.period = period;
        expQ.push_back(g);
        if (withDone) begin
            d.isDone = 1'b1; d.id = id; d.data = data; d.period = 0;
            expQ.push_back(d);
        end
    endtask

    task automatic waitGrants(input int target);
        int budget = 400;
        while (grantsSeen < target && budget > 0) begin
            stepCycle();
            budget--;
        end
        if (grantsSeen < target) checkOutput("grant_timeout", grantsSeen, target);
    endtask

    task automatic waitDones(input int target);
        int budget = 400;
        while (donesSeen < target && budget > 0) begin
            stepCycle();
            budget--;
        end
        if (donesSeen < target) checkOutput("done_timeout", donesSeen, target);
    endtask

    task automatic doReset();
        reset = 1'b1;
        req = '0;
        repeat (3) stepCycle();
        reset = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_grant"}, 32'(o_grant), 32'd0);
        checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_ser_start"}, 32'(o_ser_start), 32'd0);
        checkOutput({tag, "_ser_data"}, 32'(o_ser_data), 32'd0);
        checkOutput({tag, "_active_id"}, 32'(o_active_id), 32'd0);
        checkOutput({tag, "_error"}, 32'(o_error), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int gBase;
        int dBase;
        logic [DW-1:0] words [NUM_REQ];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

        // Reset state
        doReset();
        checkResetState("reset");

        // Single requester 2 sending 0xA5
        $display("[TB] single requester");
        gBase = grantsSeen; dBase = donesSeen;
        pushFrame(2, 8'hA5, 0, 1'b1);
        applyStimulus(2, 8'hA5, 1'b1);
        waitGrants(gBase + 1);
        applyStimulus(2, 8'hA5, 1'b0);
        waitDones(dBase + 1);
        checkOutput("gap_line_high0", 32'(serLine), 32'd1);
        checkOutput("gap_no_start0", 32'(o_ser_start), 32'd0);
        stepCycle();
        checkOutput("gap_line_high1", 32'(serLine), 32'd1);
        checkOutput("gap_no_start1", 32'(o_ser_start), 32'd0);

        // All four requesters held: 0,1,2,3,0,1,2,3, 13 cycles apart
        $display("[TB] continuous round robin");
        doReset();
        gBase = grantsSeen; dBase = donesSeen;
        for (int k = 0; k < 8; k++) pushFrame(k % 4, words[k % 4], (k == 0) ? 0 : 13, 1'b1);
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, words[i], 1'b1);
        waitGrants(gBase + 8);
        req = '0;
        waitDones(dBase + 8);

        // Fairness: requester 3 alone twice, then 0 and 3 both -> 0 then 3
        $display("[TB] fairness after partial idle");
        doReset();
        gBase = grantsSeen; dBase = donesSeen;
        pushFrame(3, 8'h3C, 0, 1'b1);
        pushFrame(3, 8'h3C, 13, 1'b1);
        pushFrame(0, 8'hC3, 13, 1'b1);
        pushFrame(3, 8'h3C, 13, 1'b1);
        applyStimulus(3, 8'h3C, 1'b1);
        waitGrants(gBase + 2);
        applyStimulus(0, 8'hC3, 1'b1);
        waitGrants(gBase + 3);
        applyStimulus(0, 8'hC3, 1'b0);
        waitGrants(gBase + 4);
        applyStimulus(3, 8'h3C, 1'b0);
        waitDones(dBase + 4);

        // Reset in the middle of SHIFT, then a normal frame from requester 1
        $display("[TB] reset mid-frame");
        doReset();
        gBase = grantsSeen; dBase = donesSeen;
        pushFrame(2, 8'h96, 0, 1'b0);
        applyStimulus(2, 8'h96, 1'b1);
        waitGrants(gBase + 1);
        applyStimulus(2, 8'h96, 1'b0);
        repeat (5) stepCycle();
        reset = 1'b1;
        stepCycle();
        checkResetState("midreset");
        reset = 1'b0;
        pushFrame(1, 8'h3C, 0, 1'b1);
        applyStimulus(1, 8'h3C, 1'b1);
        waitGrants(gBase + 2);
        applyStimulus(1, 8'h3C, 1'b0);
        waitDones(dBase + 1);
        checkOutput("midreset_done_count", donesSeen, dBase + 1);

        // Serializer never goes busy: error two cycles after LOAD, no done
        $display("[TB] serializer fault");
        doReset();
        gBase = grantsSeen; dBase = donesSeen;
        faultMode = 1'b1;
        pushFrame(1, 8'h0F, 0, 1'b0);
        applyStimulus(1, 8'h0F, 1'b1);
        waitGrants(gBase + 1);
        applyStimulus(1, 8'h0F, 1'b0);
        checkOutput("fault_error_load", 32'(o_error), 32'd0);
        stepCycle();
        checkOutput("fault_error_wait1", 32'(o_error), 32'd0);
        stepCycle();
        checkOutput("fault_error_wait2", 32'(o_error), 32'd0);
        stepCycle();
        checkOutput("fault_error_set", 32'(o_error), 32'd1);
        faultMode = 1'b0;
        repeat (4) stepCycle();
        pushFrame(2, 8'hF0, 0, 1'b1);
        applyStimulus(2, 8'hF0, 1'b1);
        waitGrants(gBase + 2);
        applyStimulus(2, 8'hF0, 1'b0);
        waitDones(dBase + 1);
        checkOutput("fault_error_sticky", 32'(o_error), 32'd1);
        doReset();
        checkOutput("fault_error_cleared", 32'(o_error), 32'd0);

        // Requester 1 pulses during SHIFT and must not be served
        $display("[TB] withdrawn request");
        doReset();
        gBase = grantsSeen; dBase = donesSeen;
        pushFrame(0, 8'h81, 0, 1'b1);
        pushFrame(2, 8'h42, 13, 1'b1);
        applyStimulus(0, 8'h81, 1'b1);
        waitGrants(gBase + 1);
        applyStimulus(0, 8'h81, 1'b0);
        repeat (4) stepCycle();
        applyStimulus(2, 8'h42, 1'b1);
        applyStimulus(1, 8'h99, 1'b1);
        stepCycle();
        applyStimulus(1, 8'h99, 1'b0);
        waitGrants(gBase + 2);
        applyStimulus(2, 8'h42, 1'b0);
        waitDones(dBase + 2);

        repeat (20) stepCycle();
        checkOutput("queue_empty", expQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
# serial_tx_arbiter

Round-robin arbiter that shares one `serializer` instance among `NUM_REQ` parallel-word requesters. It accepts one word at a time, launches the serializer with a one-cycle `start`, and tracks the serializer's `busy` to frame completion. It then enforces an idle-high inter-frame gap before granting the next requester. The block sits between the byte producers and the single serial output line.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: word width; must match the serializer instance.
- `GAP_CYCLES`, 2: idle cycles (≥1) inserted after each frame before the next grant.
- `clock`  in  1: rising-edge clock; drives this block and the serializer.
- `reset`  in  1: synchronous, active-high; also wired to the serializer reset.
- `req`  in  NUM_REQ: per-requester level request; held until `grant` bit seen.
- `req_data`  in  NUM_REQ*DATA_WIDTH: requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH]; valid while `req[i]`=1.
- `grant`  out  NUM_REQ: one-hot, one-cycle pulse; word captured.
- `done`  out  NUM_REQ: one-hot, one-cycle pulse; that requester's frame fully shifted out.
- `active_id`  out  $clog2(NUM_REQ): index of requester owning the serializer (valid when `ser_busy` or state≠IDLE).
- `error`  out  1: sticky; serializer failed to go busy after `start`. Cleared only by reset.
- `ser_start`  out  1: to serializer `start`.
- `ser_data`  out  DATA_WIDTH: to serializer `data_in`.
- `ser_busy`  in  1: from serializer `busy`.

## Operation
- Serializer contract: it samples `start`/`data_in` on a rising edge while idle. `busy` is high for exactly DATA_WIDTH cycles starting the cycle after. Bits go out LSB first, and the line idles high.
- The FSM has five states:
  - IDLE
    - If `req`≠0 at the edge, select a winner, latch `req_data` of the winner into `data_q`, and set `active_id`.
    - Drive the `grant` bit of the winner for the next cycle, then go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD: `ser_start`=1 for this single cycle, then go to WAIT.
  - WAIT
    - If `ser_busy`=1, go to SHIFT.
    - If `ser_busy`=0 for 2 consecutive edges in WAIT, set `error`, skip `done`, and go to GAP.
  - SHIFT: on the first edge with `ser_busy`=0, pulse the `done` bit of `active_id` for the next cycle and go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Round-robin arbitration:
  - The search starts at `last_id`+1 (mod NUM_REQ) and takes the first asserted `req` bit; `last_id` updates to the winner.
  - After reset, `last_id`=NUM_REQ-1, so requester 0 has top priority.
- `ser_data` always equals `data_q`, and is stable from LOAD through SHIFT.
- `ser_start` is decoded from the state register (LOAD only). It is never asserted in any other state.
- A requester deasserting `req` before its grant is simply not selected; no state is affected.
- Requests arriving outside IDLE wait; there is no queueing beyond the `req` level.

## Timing
- Reset values: state IDLE, `grant`=0, `done`=0, `ser_start`=0, `ser_data`=0, `active_id`=0, `error`=0, `last_id`=NUM_REQ-1.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No `done` is issued for the aborted frame, and the serializer aborts on the shared reset.
- Cycle-level sequence, with edge E0 being the IDLE edge that sees `req`:
  - `grant` high E0–E1, and `ser_start` high E0–E1 (LOAD).
  - The serializer samples at E1; `ser_busy` is high E1–E1+DATA_WIDTH.
  - WAIT at E2 sees busy and moves to SHIFT.
  - SHIFT sees busy low at E1+DATA_WIDTH+1; `done` is high the following cycle.
  - GAP then lasts GAP_CYCLES cycles, and IDLE is re-entered at E1+DATA_WIDTH+1+GAP_CYCLES.
- Throughput: one frame per DATA_WIDTH+GAP_CYCLES+3 cycles under continuous requests. With defaults this is 13 cycles.
- `grant` and `done` for the same requester never overlap. A requester may re-request the cycle after its `grant`.

## Test plan
- Single requester: reset, then `req[2]`=1 with data 0xA5.
  - `grant`=0100 for 1 cycle, then `ser_start` 1 cycle with `ser_data`=0xA5.
  - Serial line shows 1,0,1,0,0,1,0,1 (LSB first), then `done`=0100; idle high ≥2 cycles.
- All four requesting continuously with data 0x11, 0x22, 0x33, 0x44.
  - Grants follow 0,1,2,3,0,… with frames exactly 13 cycles apart.
  - Each frame's serialized word matches its requester; `active_id` tracks the grant.
- Fairness after partial idle: only `req[3]` active for 2 frames, then `req[0]`, `req[3]` both asserted.
  - Next grant goes to 0, then 3.
- Reset asserted 4 cycles into SHIFT.
  - All outputs go to zero next cycle with no `done`.
  - Then `req[1]`=1 → requester 1 is granted and its frame completes normally.
- Fault injection: hold the serializer `busy` model at 0.
  - `error` rises 2 cycles after LOAD and no `done` is issued.
  - Arbitration resumes after GAP; `error` stays 1 until reset.
- Withdrawn request: `req[1]` pulsed for 1 cycle while another frame is in SHIFT.
  - No grant to 1; the next IDLE serves only the remaining requesters.
